// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
// Operation codes, sequencer states and burst threshold.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_JOHN = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [2:0] MODE_FIRST_BURST = 3'b010;

endpackage

// File: rtl/shift_core.sv
// Combinational next-state for one shift operation.
// Shared by the single-step and burst paths.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_cur,
  input  mode_t            i_mode,
  input  logic             i_ser_in,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_nxt,
  output logic             o_ser,
  output logic             o_shifted
);

  // Left ops expose the old MSB, right ops the old LSB.
  always_comb begin
    o_nxt     = i_cur;
    o_ser     = 1'b0;
    o_shifted = 1'b0;
    unique case (i_mode)
      MODE_HOLD: o_nxt = i_cur;
      MODE_LOAD: o_nxt = i_in;
      MODE_SHL: begin
        o_nxt     = {i_cur[WIDTH-2:0], i_ser_in};
        o_ser     = i_cur[WIDTH-1];
        o_shifted = 1'b1;
      end
      MODE_SHR: begin
        o_nxt     = {i_ser_in, i_cur[WIDTH-1:1]};
        o_ser     = i_cur[0];
        o_shifted = 1'b1;
      end
      MODE_ROL: begin
        o_nxt     = {i_cur[WIDTH-2:0], i_cur[WIDTH-1]};
        o_ser     = i_cur[WIDTH-1];
        o_shifted = 1'b1;
      end
      MODE_ROR: begin
        o_nxt     = {i_cur[0], i_cur[WIDTH-1:1]};
        o_ser     = i_cur[0];
        o_shifted = 1'b1;
      end
      MODE_ASR: begin
        o_nxt     = {i_cur[WIDTH-1], i_cur[WIDTH-1:1]};
        o_ser     = i_cur[0];
        o_shifted = 1'b1;
      end
      MODE_JOHN: begin
        o_nxt     = {i_cur[WIDTH-2:0], ~i_cur[WIDTH-1]};
        o_ser     = i_cur[WIDTH-1];
        o_shifted = 1'b1;
      end
      default: o_nxt = i_cur;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with burst sequencer.
// Single-step in IDLE; Start runs a counted burst.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_ser_in,
  input  logic             i_start,
  input  logic [CW-1:0]    i_count,
  output logic [WIDTH-1:0] o_out,
  output logic             o_ser_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t           r_state;
  mode_t            r_mode;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_ser;
  logic             r_busy;
  logic             r_done;

  mode_t            w_mode;
  logic [WIDTH-1:0] w_nxt;
  logic             w_ser;
  logic             w_shifted;
  logic             w_burst;

  // Core sees the latched op during a burst, live op otherwise.
  always_comb begin
    w_mode  = mode_t'(i_mode);
    w_burst = i_start && (i_mode >= MODE_FIRST_BURST)
              && (i_count != '0);
    if (r_state == ST_RUN) w_mode = r_mode;
  end

  shift_core #(.WIDTH(WIDTH)) u_core (
    .i_cur     (r_out),
    .i_mode    (w_mode),
    .i_ser_in  (i_ser_in),
    .i_in      (i_in),
    .o_nxt     (w_nxt),
    .o_ser     (w_ser),
    .o_shifted (w_shifted)
  );

  // Sequencer, burst counter and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_out   <= '0;
      r_ser   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_burst) begin
            r_mode  <= mode_t'(i_mode);
            r_cnt   <= i_count;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_out <= w_nxt;
            if (w_shifted) r_ser <= w_ser;
            if (i_start) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_out <= w_nxt;
          if (w_shifted) r_ser <= w_ser;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_out     = r_out;
  assign o_ser_out = r_ser;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg.
// Arithmetic reference model, directed plus random stimulus.
module tb_univ_shift_reg;

  localparam int W  = 6;
  localparam int CW = 4;
  localparam int H  = 1 << (W - 1);
  localparam int M  = 1 << W;

  typedef struct {
    int out;
    bit ser;
    bit busy;
    bit done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    mode = '0;
  logic [W-1:0]  din = '0;
  logic          sin = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cnt = '0;
  logic [W-1:0]  out;
  logic          ser, busy, done;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  int m_out, m_left, m_lm;
  bit m_ser, m_done;

  univ_shift_reg #(.WIDTH(W), .CW(CW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_mode    (mode),
    .i_in      (din),
    .i_ser_in  (sin),
    .i_start   (start),
    .i_count   (cnt),
    .o_out     (out),
    .o_ser_out (ser),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  function automatic void apply(int m, int d, bit s);
    int o;
    o = m_out;
    case (m)
      0: ;
      1: m_out = d;
      2: begin m_out = (o * 2 + s) % M;        m_ser = (o >= H); end
      3: begin m_out = s * H + o / 2;          m_ser = o % 2; end
      4: begin m_out = (o * 2) % M + o / H;    m_ser = (o >= H); end
      5: begin m_out = (o % 2) * H + o / 2;    m_ser = o % 2; end
      6: begin m_out = o / 2 + (o >= H ? H : 0); m_ser = o % 2; end
      default: begin
        m_out = (o * 2) % M + (o >= H ? 0 : 1);
        m_ser = (o >= H);
      end
    endcase
  endfunction

  function automatic void model_reset();
    m_out = 0; m_ser = 0; m_left = 0; m_lm = 0; m_done = 0;
  endfunction

  task automatic step(int md, int d, bit s, bit st, int c);
    exp_t e;
    @(negedge clk);
    mode = md[2:0]; din = d[W-1:0]; sin = s;
    start = st; cnt = c[CW-1:0];
    if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      apply(m_lm, d, s);
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (st && md >= 2 && c != 0) begin
      m_lm = md;
      m_left = c;
    end else begin
      apply(md, d, s);
      if (st) m_done = 1;
    end
    e.out = m_out; e.ser = m_ser;
    e.busy = (m_left > 0); e.done = m_done;
    q.push_back(e);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out !== '0 || ser !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst: got out=%0d ser=%b busy=%b done=%b want all 0",
               out, ser, busy, done);
    end
    model_reset();
    #1 rst = 1'b0;
  endtask

  // Monitor: every edge the DUT presents a new output word.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (out !== e.out[W-1:0] || ser !== e.ser ||
          busy !== e.busy || done !== e.done) begin
        n_bad++;
        $display("FAIL cycle@%0t: got out=%0d ser=%b busy=%b done=%b want out=%0d ser=%b busy=%b done=%b",
                 $time, out, ser, busy, done, e.out, e.ser, e.busy, e.done);
      end
      n_cmp++;
      if (busy === 1'b1 && done === 1'b1) begin
        n_bad++;
        $display("FAIL busy_done_overlap@%0t: got both 1 want not both", $time);
      end
    end
  end

  initial begin
    int waitc;
    model_reset();
    #3;
    n_cmp++;
    if (out !== '0 || ser !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got out=%0d ser=%b busy=%b done=%b want all 0",
               out, ser, busy, done);
    end
    #4 rst = 1'b0;

    // Single-step loads.
    step(1, 32, 0, 0, 0);
    step(1, 24, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // ROL burst of 3 on 32.
    step(1, 32, 0, 0, 0);
    step(4, 0, 0, 1, 3);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    // SHR single-step then ASR burst.
    step(1, 24, 0, 0, 0);
    step(3, 0, 1, 0, 0);
    step(1, 32, 0, 0, 0);
    step(6, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    // JOHN bursts from reset.
    async_reset();
    step(7, 0, 0, 1, 6);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    step(7, 0, 0, 1, 6);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    // Count=0 start, then start during RUN ignored.
    step(1, 5, 0, 0, 0);
    step(4, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(5, 0, 0, 1, 4);
    step(2, 7, 1, 1, 9);
    for (int i = 0; i < 6; i++) step(1, 9, 0, 1, 15);
    step(0, 0, 0, 0, 0);
    // Reset after 2 of 5 ops, then a fresh burst.
    step(1, 33, 0, 0, 0);
    step(4, 0, 0, 1, 5);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    async_reset();
    step(1, 45, 0, 0, 0);
    step(2, 0, 1, 1, 2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7), $urandom_range(0, M - 1),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           $urandom_range(0, (1 << CW) - 1));
    end

    waitc = 0;
    while (q.size() > 0 && waitc < 20) begin
      @(posedge clk);
      waitc++;
    end
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
